// File: rtl/fetch_unit.sv
// Instruction fetch: pipelined word reads on RAM port A, small PC/instr buffer, redirect flush.
// Optional FETCH_BYPASS_EN macro forwards a response straight to decode when the buffer is empty.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module fetch_unit #(
    parameter int                    ADDR_WIDTH = `RISCV_ADDR_WIDTH,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_we_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

    fetch_entry_t          buf_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic                  inflight, discard;
    logic [ADDR_WIDTH-1:0] fetch_pc, pend_pc;

    logic                  fifo_empty, resp_ok, byp_hit;
    logic                  deq, pop, push, issue;
    logic [CW:0]           credit;
    logic                  redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    assign fifo_empty = (count == '0);
    // A response counts only if it belongs to the current fetch stream.
    assign resp_ok    = mem_ready_i & inflight & ~discard & ~rst & ~redirect_i;

`ifdef FETCH_BYPASS_EN
    assign byp_hit = fifo_empty & resp_ok;
`else
    assign byp_hit = 1'b0;
`endif

    assign instr_valid_o = ~rst & (~fifo_empty | byp_hit);
    assign instr_o       = byp_hit ? mem_rdata_i : buf_q[rd_ptr].instr;
    assign instr_pc_o    = byp_hit ? pend_pc     : buf_q[rd_ptr].pc;

    assign deq  = instr_valid_o & instr_ready_i;
    assign pop  = deq & ~fifo_empty;
    assign push = resp_ok & ~(byp_hit & deq);

    // Slots already promised: buffered + in flight, minus the one leaving this cycle.
    assign credit = ({1'b0, count} + (CW+1)'(inflight)) - (CW+1)'(deq);
    assign issue  = ~rst & ~redirect_i & (credit < (CW+1)'(FIFO_DEPTH));

    assign mem_valid_o = issue;
    assign mem_addr_o  = fetch_pc;
    assign mem_wdata_o = '0;
    assign mem_we_o    = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            // Only a response still owed after this cycle needs to be dropped later.
            discard  <= inflight & ~mem_ready_i;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                pend_pc  <= fetch_pc;
            end
            if (mem_ready_i && discard)
                discard <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            buf_q[wr_ptr] <= {mem_rdata_i, pend_pc};
    end

endmodule
